axis_pipe_chain: RTL and testbench

Parametrised AXI4-Stream register chain: DEPTH back-to-back pipeline stages between an upstream slave port and a downstream master port. Each stage runs in one of two modes: full skid slice, which registers both the forward path and tready, or forward-only slice, which registers the forward path and passes tready combinationally. It is the drop-in stage for timing closure on long stream routes. Full throughput is sustained in both modes, and an optional occupancy port reports how many beats are held inside the chain.

---
 rtl/axis_pipe_chain.sv | 182 ++++++++++++++++++
 tb/tb_axis_pipe_chain.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pipe_chain.sv
// axis_pipe_chain: DEPTH back-to-back AXI4-Stream register stages, full skid (MODE 0) or forward-only (MODE 1).
// Define AXIS_PIPE_CHAIN_OCC_EN to build the occupancy port and its counter.
module axis_pipe_chain #(
    parameter int DSIZE = 32,
    parameter int KSIZE = DSIZE / 8,
    parameter int USIZE = 1,
    parameter int DEPTH = 2,
    parameter int MODE  = 0
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             aclken,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [DSIZE-1:0] s_tdata,
    input  logic [KSIZE-1:0] s_tkeep,
    input  logic [USIZE-1:0] s_tuser,
    input  logic             s_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [DSIZE-1:0] m_tdata,
    output logic [KSIZE-1:0] m_tkeep,
    output logic [USIZE-1:0] m_tuser,
    output logic             m_tlast
`ifdef AXIS_PIPE_CHAIN_OCC_EN
    ,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
`endif
);

    localparam int W = DSIZE + KSIZE + USIZE + 1;

    // Handshake: a beat moves across any stage boundary only when valid && ready && aclken
    // at a rising edge; valid never waits on ready, and a presented beat is held until taken.
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_t;

    logic [W-1:0] s_beat;
    logic         rel_q;

    assign s_beat = {s_tdata, s_tkeep, s_tuser, s_tlast};

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("axis_pipe_chain: DEPTH must be in 1..16");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("axis_pipe_chain: MODE must be 0 or 1");
    end

    // Keeps s_tready low until the first enabled edge after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rel_q <= 1'b0;
        end else if (aclken) begin
            rel_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic         in_vld;
        logic [W-1:0] in_beat;
        logic         in_rdy;
        logic         out_vld;
        logic [W-1:0] out_beat;
        logic         out_rdy;
        logic         in_x;
        logic         out_x;

        if (k == 0) begin : g_head
            assign in_vld  = s_tvalid && rel_q;
            assign in_beat = s_beat;
        end else begin : g_link
            assign in_vld  = g_stage[k-1].out_vld;
            assign in_beat = g_stage[k-1].out_beat;
        end

        if (k == DEPTH - 1) begin : g_tail
            assign out_rdy = m_tready;
        end else begin : g_next
            assign out_rdy = g_stage[k+1].in_rdy;
        end

        assign in_x  = in_vld && in_rdy && aclken;
        assign out_x = out_vld && out_rdy && aclken;

        if (MODE == 0) begin : g_skid
            stage_state_t state_q, state_d;
            logic [W-1:0] main_q, main_d, skid_q, skid_d;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    state_q <= ST_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (in_x) begin
                            state_d = ST_ONE;
                            main_d  = in_beat;
                        end
                    end
                    ST_ONE: begin
                        if (in_x && out_x) begin
                            main_d = in_beat;
                        end else if (in_x) begin
                            state_d = ST_TWO;
                            skid_d  = in_beat;
                        end else if (out_x) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // Ready is low here, so only the drain can happen.
                        if (out_x) begin
                            state_d = ST_ONE;
                            main_d  = skid_q;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end

            assign in_rdy   = (state_q != ST_TWO);
            assign out_vld  = (state_q != ST_EMPTY);
            assign out_beat = main_q;
        end else begin : g_fwd
            logic         vld_q;
            logic [W-1:0] beat_q;

            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    vld_q  <= 1'b0;
                    beat_q <= '0;
                end else if (in_x) begin
                    vld_q  <= 1'b1;
                    beat_q <= in_beat;
                end else if (out_x) begin
                    vld_q  <= 1'b0;
                end
            end

            assign in_rdy   = !vld_q || out_rdy;
            assign out_vld  = vld_q;
            assign out_beat = beat_q;
        end
    end

    assign s_tready = rel_q && g_stage[0].in_rdy;
    assign m_tvalid = g_stage[DEPTH-1].out_vld;
    assign {m_tdata, m_tkeep, m_tuser, m_tlast} = g_stage[DEPTH-1].out_beat;

`ifdef AXIS_PIPE_CHAIN_OCC_EN
    localparam int OW = $clog2(2 * DEPTH + 1);

    logic in_fire;
    logic out_fire;

    assign in_fire  = s_tvalid && s_tready && aclken;
    assign out_fire = m_tvalid && m_tready && aclken;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            occupancy <= '0;
        end else if (in_fire && !out_fire) begin
            occupancy <= occupancy + OW'(1);
        end else if (out_fire && !in_fire) begin
            occupancy <= occupancy - OW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_axis_pipe_chain.sv
// Bench for axis_pipe_chain: a MODE 0 chain (DEPTH 3) and a MODE 1 chain (DEPTH 2) side by side,
// each with its own expected queue and output monitor.
module tb_axis_pipe_chain;

    localparam int DSIZE  = 32;
    localparam int KSIZE  = 4;
    localparam int USIZE  = 1;
    localparam int W      = DSIZE + KSIZE + USIZE + 1;
    localparam int DEP0   = 3;
    localparam int DEP1   = 2;
    localparam int BUDGET = 4000;
    localparam int NRAND  = 2000;

    logic             aclk    = 1'b0;
    logic             aresetn = 1'b0;
    logic             aclken  = 1'b1;
    logic             s_tvalid [2];
    logic             s_tready [2];
    logic [DSIZE-1:0] s_data   [2];
    logic [KSIZE-1:0] s_keep   [2];
    logic [USIZE-1:0] s_user   [2];
    logic             s_last   [2];
    logic             m_tvalid [2];
    logic             m_tready [2];
    logic [DSIZE-1:0] m_data   [2];
    logic [KSIZE-1:0] m_keep   [2];
    logic [USIZE-1:0] m_user   [2];
    logic             m_last   [2];
`ifdef AXIS_PIPE_CHAIN_OCC_EN
    logic [2:0]       occ      [2];
    int               occ_model[2];
`endif

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;
    int first_in  [2];
    int first_out [2];
    int last_out  [2];
    bit hold_chk = 1'b0;
    bit rand_on  = 1'b0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axis_pipe_chain #(.DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE), .DEPTH(DEP0), .MODE(0)) u_mode0 (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
        .s_tvalid(s_tvalid[0]), .s_tready(s_tready[0]),
        .s_tdata(s_data[0]), .s_tkeep(s_keep[0]), .s_tuser(s_user[0]), .s_tlast(s_last[0]),
        .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]),
        .m_tdata(m_data[0]), .m_tkeep(m_keep[0]), .m_tuser(m_user[0]), .m_tlast(m_last[0])
`ifdef AXIS_PIPE_CHAIN_OCC_EN
        , .occupancy(occ[0])
`endif
    );

    axis_pipe_chain #(.DSIZE(DSIZE), .KSIZE(KSIZE), .USIZE(USIZE), .DEPTH(DEP1), .MODE(1)) u_mode1 (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
        .s_tvalid(s_tvalid[1]), .s_tready(s_tready[1]),
        .s_tdata(s_data[1]), .s_tkeep(s_keep[1]), .s_tuser(s_user[1]), .s_tlast(s_last[1]),
        .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]),
        .m_tdata(m_data[1]), .m_tkeep(m_keep[1]), .m_tuser(m_user[1]), .m_tlast(m_last[1])
`ifdef AXIS_PIPE_CHAIN_OCC_EN
        , .occupancy(occ[1])
`endif
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [W-1:0] mk_beat(input int v, input bit last);
        logic [DSIZE-1:0] d;
        d = v;
        return {d, d[7:4], d[1], last};
    endfunction

    task automatic push(input int u, input logic [W-1:0] b);
        if (u == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    // ---------------- drivers ----------------
    // Called aligned to a negedge; returns aligned to a negedge.
    task automatic send_n(input int u, input int n, input int base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [W-1:0] b;
            int           t;
            bit           done;
            b    = mk_beat(base + i, i == n - 1);
            t    = 0;
            done = 1'b0;
            if (rnd) begin
                s_tvalid[u] = 1'b0;
                while ($urandom_range(0, 1) == 0) @(negedge aclk);
            end
            s_tvalid[u] = 1'b1;
            {s_data[u], s_keep[u], s_user[u], s_last[u]} = b;
            while (!done) begin
                #4;
                if (aresetn && aclken && s_tready[u]) begin
                    done = 1'b1;
                    push(u, b);
                    if (first_in[u] < 0) first_in[u] = cyc;
                end
                @(negedge aclk);
                t++;
                if (!done && t > BUDGET) begin
                    fail($sformatf("send_timeout_u%0d", u));
                    s_tvalid[u] = 1'b0;
                    return;
                end
            end
        end
        s_tvalid[u] = 1'b0;
    endtask

    task automatic fill(input int u, input int cap);
        int acc;
        acc = 0;
        s_tvalid[u] = 1'b1;
        for (int c = 0; c < 4 * cap + 4; c++) begin
            logic [W-1:0] b;
            b = mk_beat(256 + acc, 1'b0);
            {s_data[u], s_keep[u], s_user[u], s_last[u]} = b;
            #4;
            if (acc == cap) check($sformatf("full_s_tready_u%0d", u), s_tready[u], 0);
            if (aclken && s_tready[u]) begin
                push(u, b);
                acc++;
            end
            @(negedge aclk);
        end
        s_tvalid[u] = 1'b0;
        check($sformatf("fill_count_u%0d", u), acc, cap);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < BUDGET) begin
            @(negedge aclk);
            t++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) fail("drain_timeout");
        repeat (4) @(negedge aclk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always begin
        @(negedge aclk);
        #4;
        for (int u = 0; u < 2; u++) begin
            if (aresetn && aclken && m_tvalid[u] && m_tready[u]) begin
                logic [W-1:0] got;
                logic [W-1:0] want;
                got = {m_data[u], m_keep[u], m_user[u], m_last[u]};
                if (first_out[u] < 0) first_out[u] = cyc;
                last_out[u] = cyc;
                if (u == 0 && exp_q0.size() == 0) begin
                    fail("unexpected_beat_u0");
                end else if (u == 1 && exp_q1.size() == 0) begin
                    fail("unexpected_beat_u1");
                end else begin
                    if (u == 0) want = exp_q0.pop_front();
                    else        want = exp_q1.pop_front();
                    check($sformatf("beat_u%0d", u), got, want);
                end
            end
        end
    end

    // Outputs must not move across an edge with aclken low.
    always begin
        @(negedge aclk);
        #4;
        if (hold_chk && aresetn && !aclken) begin
            logic [W-1:0] snap0;
            logic [W-1:0] snap1;
            logic         v0;
            logic         v1;
            snap0 = {m_data[0], m_keep[0], m_user[0], m_last[0]};
            snap1 = {m_data[1], m_keep[1], m_user[1], m_last[1]};
            v0    = m_tvalid[0];
            v1    = m_tvalid[1];
            @(posedge aclk);
            #1;
            check("hold_beat_u0", {m_data[0], m_keep[0], m_user[0], m_last[0]}, snap0);
            check("hold_beat_u1", {m_data[1], m_keep[1], m_user[1], m_last[1]}, snap1);
            check("hold_valid_u0", m_tvalid[0], v0);
            check("hold_valid_u1", m_tvalid[1], v1);
        end
    end

`ifdef AXIS_PIPE_CHAIN_OCC_EN
    always begin
        @(negedge aclk);
        #4;
        for (int u = 0; u < 2; u++) begin
            if (!aresetn) begin
                occ_model[u] = 0;
                check($sformatf("occupancy_reset_u%0d", u), occ[u], 0);
            end else begin
                check($sformatf("occupancy_u%0d", u), occ[u], occ_model[u]);
                occ_model[u] += int'(s_tvalid[u] && s_tready[u] && aclken)
                              - int'(m_tvalid[u] && m_tready[u] && aclken);
            end
        end
    end
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int u = 0; u < 2; u++) begin
            s_tvalid[u]  = 1'b0;
            s_data[u]    = '0;
            s_keep[u]    = '0;
            s_user[u]    = '0;
            s_last[u]    = 1'b0;
            m_tready[u]  = 1'b0;
            first_in[u]  = -1;
            first_out[u] = -1;
            last_out[u]  = -1;
        end
        aresetn = 1'b0;
        aclken  = 1'b1;

        // Reset held for 5 cycles
        repeat (5) begin
            @(negedge aclk);
            #4;
            for (int u = 0; u < 2; u++) begin
                check($sformatf("reset_s_tready_u%0d", u), s_tready[u], 0);
                check($sformatf("reset_m_tvalid_u%0d", u), m_tvalid[u], 0);
                check($sformatf("reset_m_tdata_u%0d", u), m_data[u], 0);
            end
        end
        @(negedge aclk);
        aresetn = 1'b1;
        #4;
        check("release_s_tready_u0_pre", s_tready[0], 0);
        check("release_s_tready_u1_pre", s_tready[1], 0);
        @(negedge aclk);
        check("release_s_tready_u0", s_tready[0], 1);
        check("release_s_tready_u1", s_tready[1], 1);

        // Streaming, 100 beats, m_tready held high
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        fork
            send_n(0, 100, 0, 1'b0);
            send_n(1, 100, 0, 1'b0);
        join
        drain();
        check("latency_u0", first_out[0] - first_in[0], DEP0);
        check("latency_u1", first_out[1] - first_in[1], DEP1);
        check("contiguous_u0", last_out[0] - first_out[0], 99);
        check("contiguous_u1", last_out[1] - first_out[1], 99);

        // Fill with downstream stalled, then release
        m_tready[0] = 1'b0;
        m_tready[1] = 1'b0;
        fork
            fill(0, 2 * DEP0);
            fill(1, DEP1);
        join
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        drain();

        // Random valid/ready
        rand_on = 1'b1;
        fork
            begin
                fork
                    send_n(0, NRAND, 4096, 1'b1);
                    send_n(1, NRAND, 8192, 1'b1);
                join
                rand_on = 1'b0;
            end
            begin
                while (rand_on) begin
                    m_tready[0] = ($urandom_range(0, 1) == 1);
                    m_tready[1] = ($urandom_range(0, 1) == 1);
                    @(negedge aclk);
                end
            end
        join
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        drain();

        // aclken low every 3rd cycle while streaming
        hold_chk = 1'b1;
        fork
            send_n(0, 60, 'h3000, 1'b0);
            send_n(1, 60, 'h4000, 1'b0);
            begin
                for (int k = 0; k < 200; k++) begin
                    aclken = (k % 3 != 2);
                    @(negedge aclk);
                end
                aclken = 1'b1;
            end
        join
        drain();
        hold_chk = 1'b0;

        // Reset asserted with beats held mid-packet
        m_tready[0] = 1'b0;
        m_tready[1] = 1'b0;
        fork
            send_n(0, 3, 'h5000, 1'b0);
            send_n(1, 2, 'h6000, 1'b0);
        join
        #1;
        check("pre_reset_m_tvalid_u0", m_tvalid[0], 1);
        check("pre_reset_m_tvalid_u1", m_tvalid[1], 1);
        #1;
        aresetn = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("async_reset_m_tvalid_u%0d", u), m_tvalid[u], 0);
            check($sformatf("async_reset_m_beat_u%0d", u), {m_data[u], m_keep[u], m_user[u], m_last[u]}, 0);
            check($sformatf("async_reset_s_tready_u%0d", u), s_tready[u], 0);
        end
        exp_q0.delete();
        exp_q1.delete();
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        m_tready[0] = 1'b1;
        m_tready[1] = 1'b1;
        repeat (4) @(negedge aclk);
        check("post_reset_m_tvalid_u0", m_tvalid[0], 0);
        check("post_reset_m_tvalid_u1", m_tvalid[1], 0);
        check("post_reset_s_tready_u0", s_tready[0], 1);
        check("post_reset_s_tready_u1", s_tready[1], 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
